hazard_stall_controller: RTL and testbench
==========================================

# hazard_stall_controller

Central pipeline sequencer for the 5-stage MIPS core. It drives the 2-bit stage-control codes of the IF/ID, ID/EX and EX/MEM registers, plus the PC write enable. It detects load-use hazards, redirects on taken branches/jumps resolved in EX, and freezes the pipe while data memory is busy. It also keeps saturating stall and flush counters for debug.

## Interface
Parameters:
- REDIRECT_CYCLES, 1: cycles IF/ID is flushed after a redirect (range 1–7).
- CNT_W, 16: width of the performance counters.

Ports:
- Clk  in  1  pipeline clock; all state changes on posedge.
- Rst_n  in  1  reset, asynchronous, active-low.
- ID_Rs, ID_Rt  in  5 each  source registers of the instruction in ID.
- ID_UsesRs, ID_UsesRt  in  1 each  the ID instruction actually reads Rs / Rt.
- EX_MemRead  in  2  MemRead code of the instruction in EX; non-zero means it is a load.
- EX_RegWrite  in  1  the EX instruction writes a register.
- EX_WriteReg  in  5  destination register of the EX instruction.
- EX_Redirect  in  1  a taken branch, jump or jr resolved in EX this cycle.
- MEM_Busy  in  1  data memory is not ready; the MEM stage must hold.
- PC_Write  out  1  PC load enable.
- IF_ID_Signal, ID_EX_Signal, EX_MEM_Signal  out  2 each  stage code: 0 = LOAD, 1 = HOLD, 2 = FLUSH (inserts a bubble with MemToReg = 1 and all other controls 0). Code 3 is never driven.
- StallCycles, FlushCount  out  CNT_W each  saturating event counters.

## Operation
- FSM states: RUN, REDIRECT, MEMWAIT.
- Priority within a cycle: MEM_Busy > EX_Redirect > load-use > normal.
- Load-use hazard (LU) is true when all of the following hold:
  - EX_MemRead ≠ 0,
  - EX_RegWrite = 1,
  - EX_WriteReg ≠ 0,
  - (ID_UsesRs and ID_Rs = EX_WriteReg) or (ID_UsesRt and ID_Rt = EX_WriteReg).
- Any state with MEM_Busy = 1:
  - PC_Write = 0, IF_ID = ID_EX = EX_MEM = HOLD.
  - Next state is MEMWAIT. The redirect counter is frozen; a pending redirect resumes afterwards.
- RUN:
  - EX_Redirect: PC_Write = 1, IF_ID = FLUSH, ID_EX = FLUSH, EX_MEM = LOAD. Load the counter with REDIRECT_CYCLES−1; go to REDIRECT if REDIRECT_CYCLES > 1, else stay in RUN.
  - LU (no redirect): PC_Write = 0, IF_ID = HOLD, ID_EX = FLUSH, EX_MEM = LOAD. Stay in RUN. The hazard clears naturally next cycle because a bubble then occupies EX.
  - Otherwise: PC_Write = 1 and all stages LOAD.
- REDIRECT:
  - PC_Write = 1, IF_ID = FLUSH, ID_EX = LOAD, EX_MEM = LOAD.
  - Decrement the counter; return to RUN when it reaches 0.
  - LU is ignored here because ID holds a bubble. A new EX_Redirect reloads the counter and flushes IF/ID and ID/EX.
- MEMWAIT:
  - Behaves as RUN/REDIRECT once MEM_Busy = 0. It returns to the state held before the wait: a 1-bit resume flag records whether that was REDIRECT.
- Counters:
  - StallCycles increments on every cycle with PC_Write = 0.
  - FlushCount increments on every cycle in which any stage code is FLUSH.
  - Both saturate at all-ones.

## Timing
- All outputs are combinational from the current state and inputs. Pipeline registers sample them at the next posedge, so a hazard costs 0 detection latency.
- Load-use penalty: exactly 1 bubble.
- Redirect penalty: REDIRECT_CYCLES + 1 squashed instructions (IF/ID flushed REDIRECT_CYCLES times, ID/EX flushed once).
- While Rst_n = 0:
  - state = RUN, counters = 0, resume flag = 0, redirect counter = 0.
  - Outputs forced to PC_Write = 0 and all three stage codes FLUSH, so the pipe fills with bubbles.
- Rst_n asserted mid-redirect or mid-wait aborts the sequence immediately and asynchronously. The first posedge after deassertion behaves as RUN.
- A simultaneous EX_Redirect and LU is a redirect: the stalled ID instruction is squashed anyway.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - stage-code constants PIPE_LOAD = 2'd0, PIPE_HOLD = 2'd1, PIPE_FLUSH = 2'd2;
  - the FSM state enum.
  - All pipeline registers use the same package.
- One sub-module, sat_counter (parameter W; inputs Clk, Rst_n, inc), instantiated twice.
- The LU comparator stays inline.

## Test plan
- Load-use: `lw $8` in EX with EX_MemRead = 3, `add` in ID with ID_Rs = 8, ID_UsesRs = 1 -> exactly one cycle of PC_Write = 0, IF_ID = 1, ID_EX = 2; then all LOAD; StallCycles = 1, FlushCount = 1.
- Register $0 and unused operands: same as above but EX_WriteReg = 0, or ID_UsesRs = 0 -> no stall, all stages LOAD.
- Redirect with REDIRECT_CYCLES = 3: EX_Redirect pulsed for 1 cycle -> IF_ID = FLUSH for 3 cycles, ID_EX = FLUSH for the first cycle only, PC_Write = 1 throughout; FlushCount = 3.
- Memory wait inside a redirect: MEM_Busy high for 4 cycles, starting at the 2nd redirect cycle -> 4 cycles of all-HOLD with PC_Write = 0, then the 2 remaining redirect flushes; StallCycles = 4.
- Priority and reset: EX_Redirect and LU together -> redirect pattern. Rst_n dropped mid-sequence -> outputs immediately show PC_Write = 0 and all FLUSH, counters read 0.
- Saturation with CNT_W = 4: hold MEM_Busy for 20 cycles -> StallCycles stops at 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: stage codes, sequencer states and helpers
// used by the hazard/stall sequencer and every pipeline register.
package pipe_ctrl_pkg;

  localparam logic [1:0] PIPE_LOAD  = 2'd0;
  localparam logic [1:0] PIPE_HOLD  = 2'd1;
  localparam logic [1:0] PIPE_FLUSH = 2'd2;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    REDIRECT = 2'd1,
    MEMWAIT  = 2'd2
  } pipeState_e;

  function automatic logic anyFlush(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
    return (a == PIPE_FLUSH) || (b == PIPE_FLUSH) || (c == PIPE_FLUSH);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the sequencer's debug event counts.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count events, sticking at all-ones once reached.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      count <= {W{1'b0}};
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// Central 5-stage pipeline sequencer: load-use stalls, EX-resolved redirects,
// data-memory wait freezes, plus saturating stall/flush debug counters.
module hazard_stall_controller #(
  parameter int REDIRECT_CYCLES = 1,
  parameter int CNT_W           = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRs,
  input  logic             ID_UsesRt,
  input  logic [1:0]       EX_MemRead,
  input  logic             EX_RegWrite,
  input  logic [4:0]       EX_WriteReg,
  input  logic             EX_Redirect,
  input  logic             MEM_Busy,
  output logic             PC_Write,
  output logic [1:0]       IF_ID_Signal,
  output logic [1:0]       ID_EX_Signal,
  output logic [1:0]       EX_MEM_Signal,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount
);

  import pipe_ctrl_pkg::*;

  localparam logic [2:0] RELOAD = 3'(REDIRECT_CYCLES - 1);

  pipeState_e state_r;
  pipeState_e nextState_s;
  logic       resume_r;
  logic       nextResume_s;
  logic [2:0] redirCnt_r;
  logic [2:0] nextCnt_s;
  logic       inRedirect_s;
  logic       lu_s;
  logic       stallInc_s;
  logic       flushInc_s;

  assign lu_s = (EX_MemRead != 2'd0) && EX_RegWrite && (EX_WriteReg != 5'd0) &&
                ((ID_UsesRs && (ID_Rs == EX_WriteReg)) || (ID_UsesRt && (ID_Rt == EX_WriteReg)));

  // Resolve whether the current cycle behaves as a redirect cycle (MEMWAIT resumes its origin).
  always_comb begin
    inRedirect_s = 1'b0;
    case (state_r)
      RUN:      inRedirect_s = 1'b0;
      REDIRECT: inRedirect_s = 1'b1;
      MEMWAIT:  inRedirect_s = resume_r;
      default:  inRedirect_s = 1'b0;
    endcase
  end

  // Stage codes, PC enable and next-state selection in priority order.
  always_comb begin
    PC_Write      = 1'b1;
    IF_ID_Signal  = PIPE_LOAD;
    ID_EX_Signal  = PIPE_LOAD;
    EX_MEM_Signal = PIPE_LOAD;
    nextState_s   = RUN;
    nextResume_s  = 1'b0;
    nextCnt_s     = redirCnt_r;
    if (!Rst_n) begin
      PC_Write      = 1'b0;
      IF_ID_Signal  = PIPE_FLUSH;
      ID_EX_Signal  = PIPE_FLUSH;
      EX_MEM_Signal = PIPE_FLUSH;
      nextCnt_s     = 3'd0;
    end else if (MEM_Busy) begin
      PC_Write      = 1'b0;
      IF_ID_Signal  = PIPE_HOLD;
      ID_EX_Signal  = PIPE_HOLD;
      EX_MEM_Signal = PIPE_HOLD;
      nextState_s   = MEMWAIT;
      nextResume_s  = inRedirect_s;
    end else if (EX_Redirect) begin
      IF_ID_Signal  = PIPE_FLUSH;
      ID_EX_Signal  = PIPE_FLUSH;
      nextCnt_s     = RELOAD;
      nextState_s   = (REDIRECT_CYCLES > 1) ? REDIRECT : RUN;
    end else if (inRedirect_s) begin
      // ID already holds a bubble here, so a load-use match is irrelevant.
      IF_ID_Signal  = PIPE_FLUSH;
      nextCnt_s     = (redirCnt_r != 3'd0) ? (redirCnt_r - 3'd1) : 3'd0;
      nextState_s   = (redirCnt_r > 3'd1) ? REDIRECT : RUN;
    end else if (lu_s) begin
      PC_Write      = 1'b0;
      IF_ID_Signal  = PIPE_HOLD;
      ID_EX_Signal  = PIPE_FLUSH;
    end else begin
      nextState_s   = RUN;
    end
  end

  // Sequencer state register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r    <= RUN;
      resume_r   <= 1'b0;
      redirCnt_r <= 3'd0;
    end else begin
      state_r    <= nextState_s;
      resume_r   <= nextResume_s;
      redirCnt_r <= nextCnt_s;
    end
  end

  assign stallInc_s = !PC_Write;
  assign flushInc_s = anyFlush(IF_ID_Signal, ID_EX_Signal, EX_MEM_Signal);

  sat_counter #(.W(CNT_W)) uStallCnt (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .inc   (stallInc_s),
    .count (StallCycles)
  );

  sat_counter #(.W(CNT_W)) uFlushCnt (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .inc   (flushInc_s),
    .count (FlushCount)
  );

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench: per-cycle comparison against a flush-budget model plus
// directed scenarios with hand-computed stage patterns and counter values.
module tb_hazard_stall_controller;

  localparam int RC   = 3;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic [4:0]    ID_Rs = 5'd0, ID_Rt = 5'd0, EX_WriteReg = 5'd0;
  logic          ID_UsesRs = 1'b0, ID_UsesRt = 1'b0, EX_RegWrite = 1'b0;
  logic [1:0]    EX_MemRead = 2'd0;
  logic          EX_Redirect = 1'b0, MEM_Busy = 1'b0;
  logic          PC_Write;
  logic [1:0]    IF_ID_Signal, ID_EX_Signal, EX_MEM_Signal;
  logic [CW-1:0] StallCycles, FlushCount;

  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  always #5 Clk = ~Clk;

  hazard_stall_controller #(.REDIRECT_CYCLES(RC), .CNT_W(CW)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_WriteReg(EX_WriteReg),
    .EX_Redirect(EX_Redirect), .MEM_Busy(MEM_Busy),
    .PC_Write(PC_Write), .IF_ID_Signal(IF_ID_Signal), .ID_EX_Signal(ID_EX_Signal),
    .EX_MEM_Signal(EX_MEM_Signal), .StallCycles(StallCycles), .FlushCount(FlushCount)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: remaining IF/ID flushes still owed after a redirect, plus plain event counts.
  int mLeft = 0;
  int mStall = 0;
  int mFlush = 0;
  int ePc, eIf, eId, eEx;
  logic mLu;

  always_comb begin
    mLu = (EX_MemRead != 2'd0) && EX_RegWrite && (EX_WriteReg != 5'd0) &&
          ((ID_UsesRs && ID_Rs == EX_WriteReg) || (ID_UsesRt && ID_Rt == EX_WriteReg));
    ePc = 1; eIf = 0; eId = 0; eEx = 0;
    if (!Rst_n)           begin ePc = 0; eIf = 2; eId = 2; eEx = 2; end
    else if (MEM_Busy)    begin ePc = 0; eIf = 1; eId = 1; eEx = 1; end
    else if (EX_Redirect) begin ePc = 1; eIf = 2; eId = 2; eEx = 0; end
    else if (mLeft > 0)   begin ePc = 1; eIf = 2; eId = 0; eEx = 0; end
    else if (mLu)         begin ePc = 0; eIf = 1; eId = 2; eEx = 0; end
    else                  begin ePc = 1; eIf = 0; eId = 0; eEx = 0; end
  end

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      mLeft <= 0; mStall <= 0; mFlush <= 0;
    end else begin
      if (!MEM_Busy) begin
        if (EX_Redirect) mLeft <= RC - 1;
        else if (mLeft > 0) mLeft <= mLeft - 1;
      end
      if (ePc == 0 && mStall < MAXC) mStall <= mStall + 1;
      if ((eIf == 2 || eId == 2 || eEx == 2) && mFlush < MAXC) mFlush <= mFlush + 1;
    end
  end

  always @(negedge Clk) begin
    if (!done) begin
      check("model_pc",    32'(PC_Write),      32'(ePc));
      check("model_ifid",  32'(IF_ID_Signal),  32'(eIf));
      check("model_idex",  32'(ID_EX_Signal),  32'(eId));
      check("model_exmem", 32'(EX_MEM_Signal), 32'(eEx));
      check("model_stall", 32'(StallCycles),   32'(mStall));
      check("model_flush", 32'(FlushCount),    32'(mFlush));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic expectOut(input string name, input int pc, input int ifid, input int idex, input int exmem);
    #1;
    check({name, "_pc"},    32'(PC_Write),      32'(pc));
    check({name, "_ifid"},  32'(IF_ID_Signal),  32'(ifid));
    check({name, "_idex"},  32'(ID_EX_Signal),  32'(idex));
    check({name, "_exmem"}, 32'(EX_MEM_Signal), 32'(exmem));
  endtask

  task automatic clearIn();
    ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRs = 1'b0; ID_UsesRt = 1'b0;
    EX_MemRead = 2'd0; EX_RegWrite = 1'b0; EX_WriteReg = 5'd0;
    EX_Redirect = 1'b0; MEM_Busy = 1'b0;
  endtask

  task automatic setLoad(input logic [4:0] wr, input logic [4:0] rs, input logic usesRs);
    EX_MemRead = 2'd3; EX_RegWrite = 1'b1; EX_WriteReg = wr;
    ID_Rs = rs; ID_UsesRs = usesRs;
  endtask

  task automatic doReset();
    clearIn();
    Rst_n = 1'b0;
    expectOut("reset", 0, 2, 2, 2);
    check("reset_stall", 32'(StallCycles), 32'd0);
    check("reset_flush", 32'(FlushCount),  32'd0);
    tick(1);
    Rst_n = 1'b1;
  endtask

  initial begin
    doReset();

    // Load-use: lw $8 in EX, add reading $8 in ID -> one bubble.
    setLoad(5'd8, 5'd8, 1'b1);
    expectOut("lu_stall", 0, 1, 2, 0);
    tick(1);
    EX_MemRead = 2'd0; EX_RegWrite = 1'b0; EX_WriteReg = 5'd0;
    expectOut("lu_after", 1, 0, 0, 0);
    tick(1);
    check("lu_stallcnt", 32'(StallCycles), 32'd1);
    check("lu_flushcnt", 32'(FlushCount),  32'd1);

    // $0 destination and unused operand never stall; Rt match does.
    setLoad(5'd0, 5'd0, 1'b1);
    expectOut("lu_r0", 1, 0, 0, 0);
    tick(1);
    setLoad(5'd8, 5'd8, 1'b0);
    expectOut("lu_unused", 1, 0, 0, 0);
    tick(1);
    ID_Rt = 5'd8; ID_UsesRt = 1'b1;
    expectOut("lu_rt", 0, 1, 2, 0);
    tick(1);
    clearIn();
    setLoad(5'd9, 5'd9, 1'b1);
    EX_RegWrite = 1'b0;
    expectOut("lu_nowrite", 1, 0, 0, 0);
    tick(1);

    // Redirect with 3 IF/ID flushes; a load-use match mid-redirect is ignored.
    doReset();
    EX_Redirect = 1'b1;
    expectOut("rd_c1", 1, 2, 2, 0);
    tick(1);
    EX_Redirect = 1'b0;
    setLoad(5'd5, 5'd5, 1'b1);
    expectOut("rd_c2", 1, 2, 0, 0);
    tick(1);
    clearIn();
    expectOut("rd_c3", 1, 2, 0, 0);
    tick(1);
    expectOut("rd_done", 1, 0, 0, 0);
    check("rd_flushcnt", 32'(FlushCount),  32'd3);
    check("rd_stallcnt", 32'(StallCycles), 32'd0);
    tick(1);

    // Memory wait of 4 cycles starting at the second redirect cycle.
    doReset();
    EX_Redirect = 1'b1;
    tick(1);
    EX_Redirect = 1'b0;
    MEM_Busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expectOut($sformatf("mw_hold%0d", i), 0, 1, 1, 1);
      tick(1);
    end
    MEM_Busy = 1'b0;
    expectOut("mw_rd2", 1, 2, 0, 0);
    tick(1);
    expectOut("mw_rd3", 1, 2, 0, 0);
    tick(1);
    expectOut("mw_done", 1, 0, 0, 0);
    check("mw_stallcnt", 32'(StallCycles), 32'd4);
    check("mw_flushcnt", 32'(FlushCount),  32'd3);
    tick(1);

    // Redirect beats load-use; MEM_Busy beats redirect.
    doReset();
    setLoad(5'd7, 5'd7, 1'b1);
    EX_Redirect = 1'b1;
    expectOut("pri_rd_lu", 1, 2, 2, 0);
    MEM_Busy = 1'b1;
    expectOut("pri_busy", 0, 1, 1, 1);
    MEM_Busy = 1'b0;
    tick(1);
    clearIn();
    expectOut("pri_rd2", 1, 2, 0, 0);
    tick(1);

    // Asynchronous reset mid-redirect aborts immediately; restart behaves as RUN.
    Rst_n = 1'b0;
    expectOut("arst", 0, 2, 2, 2);
    check("arst_stall", 32'(StallCycles), 32'd0);
    check("arst_flush", 32'(FlushCount),  32'd0);
    tick(1);
    Rst_n = 1'b1;
    expectOut("arst_run", 1, 0, 0, 0);
    tick(1);

    // Saturation: 20 busy cycles on a 4-bit counter.
    doReset();
    MEM_Busy = 1'b1;
    tick(20);
    check("sat_stall", 32'(StallCycles), 32'd15);
    check("sat_flush", 32'(FlushCount),  32'd0);
    MEM_Busy = 1'b0;
    tick(2);

    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
